vga_buf_reader: RTL and testbench

//  Read-side consumer of vga_buf: scans the 320x240 12-bit frame buffer written by
//  the perspective mapper and drives a 640x480@60 VGA stream, pixel-doubled 2x2.

---
 rtl/vga_buf_reader.sv | 141 ++++++++++++++
 tb/tb_vga_buf_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_buf_reader.sv
// vga_buf_reader: scans the 320x240x12 frame buffer and drives 640x480@60 VGA, 2x2 pixel-doubled.
// Latency: D = RD_LATENCY+2 clk from raster counters to rgb/sync/blank; vblank_start is undelayed.
// Backpressure: none; one free-running buffer read per pixel clock. Option macro: TEST_PATTERN_EN.
module vga_buf_reader #(
  parameter int RD_LATENCY = 2,   // buffer read latency addr->data, legal 1..4
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [16:0] vga_out_addr,
  input  logic [11:0] pixel_in,
  input  logic        test_mode,
  output logic [11:0] rgb_out,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank,
  output logic        vblank_start
);

  // D counts counter stage -> address register -> RD_LATENCY -> rgb register
  localparam int D = RD_LATENCY + 2;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]   hcount_q, hcount_d;
  logic [9:0]   vcount_q, vcount_d;
  logic         active_s0, hsync_s0, vsync_s0;
  logic [16:0]  pix_addr_s0;
  logic [16:0]  addr_q, addr_d;
  logic [D-1:0] act_q, act_d;
  logic [D-1:0] hs_q, hs_d;
  logic [D-1:0] vs_q, vs_d;
  logic [11:0]  rgb_q, rgb_d;
  logic [11:0]  pix_sel;

  // Free-running raster counters: h wraps at end of line and steps v, v wraps at end of frame
  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end
  end

  // Counter-stage decode: visible area, sync windows and the half-resolution buffer address
  always_comb begin
    active_s0   = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hsync_s0    = (hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST);
    vsync_s0    = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);
    // Dropping bit 0 of each counter repeats every buffer word over 2 columns and 2 lines
    pix_addr_s0 = ({8'd0, vcount_q[9:1]} * 17'd320) + {8'd0, hcount_q[9:1]};
  end

  // Address register plus sync/active delay lines that follow the read data down the pipe
  always_comb begin
    addr_d = active_s0 ? pix_addr_s0 : 17'd0;
    act_d  = {act_q[D-2:0], active_s0};
    hs_d   = {hs_q[D-2:0], hsync_s0};
    vs_d   = {vs_q[D-2:0], vsync_s0};
  end

`ifdef TEST_PATTERN_EN
  logic [2:0]            bar_s0;
  logic [D-2:0][2:0]     bar_q, bar_d;

  // Colour-bar index (column/80) delayed to the stage where read data returns
  always_comb begin
    bar_s0 = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcount_q >= 10'(k * 80)) bar_s0 = 3'(k);
    end
    bar_d = {bar_q[D-3:0], bar_s0};
  end

  // Bar index delay line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bar_q <= '0;
    else          bar_q <= bar_d;
  end
`else
  // Without the pattern generator the mode pin has no function
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Pixel source at the data-return stage; anything outside the visible area is forced black
  always_comb begin
    pix_sel = pixel_in;
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      pix_sel = {{4{bar_q[D-2][2]}}, {4{bar_q[D-2][1]}}, {4{bar_q[D-2][0]}}};
    end
`endif
    rgb_d = act_q[D-2] ? pix_sel : 12'h000;
  end

  // All pipeline state; reset parks the raster at (0,0) with everything blanked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      addr_q   <= 17'd0;
      act_q    <= '0;
      hs_q     <= '0;
      vs_q     <= '0;
      rgb_q    <= 12'h000;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      act_q    <= act_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_out_addr = addr_q;
  assign rgb_out      = rgb_q;
  assign blank        = ~act_q[D-1];
  assign hsync_n      = ~hs_q[D-1];
  assign vsync_n      = ~vs_q[D-1];
  // Frame tick for the writer, taken straight from the counters (not pixel-aligned)
  assign vblank_start = (hcount_q == 10'd0) && (vcount_q == V_ACT);

endmodule

// File: tb/tb_vga_buf_reader.sv
`timescale 1ns/1ps
module tb_vga_buf_reader;

  // Full horizontal timing; vertical shortened so whole frames fit in a short run
  localparam int HT = 800, HA = 640, HF = 16, HS = 96;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int MEM_WORDS = 76800;

  typedef struct {
    logic [16:0] addr;
    logic [11:0] rgb;
    logic        blank;
    logic        hs_n;
    logic        vs_n;
    logic        vbs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        test_mode = 1'b0;
  logic [11:0] mem [MEM_WORDS];

  logic [16:0] addr_o [3];
  logic [11:0] rgb_o  [3];
  logic [11:0] pix_i  [3];
  logic        hs_o   [3];
  logic        vs_o   [3];
  logic        bl_o   [3];
  logic        vbs_o  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Three instances at read latency 1, 2 and 4, each with its own read-latency model of vga_buf
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [11:0] rd_pipe [L];

    always @(posedge clk) begin
      rd_pipe[0] <= mem[addr_o[g]];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign pix_i[g] = rd_pipe[L-1];

    vga_buf_reader #(
      .RD_LATENCY(L), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .vga_out_addr(addr_o[g]), .pixel_in(pix_i[g]),
      .test_mode(test_mode), .rgb_out(rgb_o[g]), .hsync_n(hs_o[g]), .vsync_n(vs_o[g]),
      .blank(bl_o[g]), .vblank_start(vbs_o[g])
    );
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  // Colour of visible screen pixel (h,v): colour bar or the doubled buffer word
  function automatic logic [11:0] pix_model(int h, int v);
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      int k;
      k = h / 80;
      return {((k & 4) != 0) ? 4'hF : 4'h0, ((k & 2) != 0) ? 4'hF : 4'h0,
              ((k & 1) != 0) ? 4'hF : 4'h0};
    end
`endif
    return mem[(v / 2) * 320 + h / 2];
  endfunction

  // Expected outputs k clock edges after reset release. The raster position after edge k is
  // pixel index k; the address shows index k-1 and the video outputs show index k-(lat+2).
  function automatic exp_t model(int k, int lat);
    exp_t e;
    int d, p, h, v;
    d = lat + 2;
    e.addr = '0; e.rgb = '0; e.blank = 1'b1; e.hs_n = 1'b1; e.vs_n = 1'b1;
    e.vbs = ((k % HT) == 0) && (((k / HT) % VT) == VA);
    if (k >= 1) begin
      p = k - 1; h = p % HT; v = (p / HT) % VT;
      if (h < HA && v < VA) e.addr = 17'((v / 2) * 320 + h / 2);
    end
    if (k >= d) begin
      p = k - d; h = p % HT; v = (p / HT) % VT;
      e.hs_n = !(h >= HA + HF && h < HA + HF + HS);
      e.vs_n = !(v >= VA + VF && v < VA + VF + VS);
      if (h < HA && v < VA) begin
        e.blank = 1'b0;
        e.rgb   = pix_model(h, v);
      end
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0; #1;
    for (int g = 0; g < 3; g++) begin
      n_cmp += 6;
      if (rgb_o[g]  !== 12'h000) begin n_bad++; $display("FAIL reset_rgb lat%0d: got %h want 000", lat_of(g), rgb_o[g]); end
      if (hs_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL reset_hsync_n lat%0d: got %b want 1", lat_of(g), hs_o[g]); end
      if (vs_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL reset_vsync_n lat%0d: got %b want 1", lat_of(g), vs_o[g]); end
      if (bl_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL reset_blank lat%0d: got %b want 1", lat_of(g), bl_o[g]); end
      if (addr_o[g] !== 17'd0)   begin n_bad++; $display("FAIL reset_addr lat%0d: got %0d want 0", lat_of(g), addr_o[g]); end
      if (vbs_o[g]  !== 1'b0)    begin n_bad++; $display("FAIL reset_vblank_start lat%0d: got %b want 0", lat_of(g), vbs_o[g]); end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Two frames with mem[a]=a[11:0]: every output every cycle, sync widths, frame tick spacing
  task automatic test_frames();
    exp_t e;
    int hs_run, vs_run, n_vbs, last_vbs;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = a[11:0];
    test_mode = 1'b0;
    do_reset();
    hs_run = 0; vs_run = 0; n_vbs = 0; last_vbs = -1;
    for (int k = 1; k <= 2 * HT * VT + 8; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        e = model(k, lat_of(g));
        n_cmp += 6;
        if (addr_o[g] !== e.addr)  begin n_bad++; $display("FAIL frame_addr lat%0d k=%0d: got %0d want %0d", lat_of(g), k, addr_o[g], e.addr); end
        if (rgb_o[g]  !== e.rgb)   begin n_bad++; $display("FAIL frame_rgb lat%0d k=%0d: got %h want %h", lat_of(g), k, rgb_o[g], e.rgb); end
        if (bl_o[g]   !== e.blank) begin n_bad++; $display("FAIL frame_blank lat%0d k=%0d: got %b want %b", lat_of(g), k, bl_o[g], e.blank); end
        if (hs_o[g]   !== e.hs_n)  begin n_bad++; $display("FAIL frame_hsync_n lat%0d k=%0d: got %b want %b", lat_of(g), k, hs_o[g], e.hs_n); end
        if (vs_o[g]   !== e.vs_n)  begin n_bad++; $display("FAIL frame_vsync_n lat%0d k=%0d: got %b want %b", lat_of(g), k, vs_o[g], e.vs_n); end
        if (vbs_o[g]  !== e.vbs)   begin n_bad++; $display("FAIL frame_vblank_start lat%0d k=%0d: got %b want %b", lat_of(g), k, vbs_o[g], e.vbs); end
        // Pixel (5,3): buffer word 1*320+2 = 322 = 0x142, so mem holds 12'h142
        if (k == 3 * HT + 5 + lat_of(g) + 2) begin
          n_cmp++;
          if (rgb_o[g] !== 12'h142) begin n_bad++; $display("FAIL pixel_5_3 lat%0d: got %h want 142", lat_of(g), rgb_o[g]); end
        end
      end
      if (hs_o[1] === 1'b0) hs_run++;
      else if (hs_run != 0) begin
        n_cmp++;
        if (hs_run !== HS) begin n_bad++; $display("FAIL hsync_width: got %0d want %0d", hs_run, HS); end
        hs_run = 0;
      end
      if (vs_o[1] === 1'b0) vs_run++;
      else if (vs_run != 0) begin
        n_cmp++;
        if (vs_run !== VS * HT) begin n_bad++; $display("FAIL vsync_width: got %0d want %0d", vs_run, VS * HT); end
        vs_run = 0;
      end
      if (vbs_o[1] === 1'b1) begin
        if (last_vbs >= 0) begin
          n_cmp++;
          if (k - last_vbs !== HT * VT) begin n_bad++; $display("FAIL vblank_period: got %0d want %0d", k - last_vbs, HT * VT); end
        end
        n_vbs++;
        last_vbs = k;
      end
    end
    n_cmp++;
    if (n_vbs !== 2) begin n_bad++; $display("FAIL vblank_count: got %0d want 2", n_vbs); end
  endtask

  // Buffer full of white: nothing may leak into blanking
  task automatic test_blanking();
    exp_t e;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 12'hFFF;
    test_mode = 1'b0;
    do_reset();
    for (int k = 1; k <= HT * VT + 6; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        e = model(k, lat_of(g));
        n_cmp += 2;
        if (e.blank) begin
          if (rgb_o[g] !== 12'h000) begin n_bad++; $display("FAIL blank_rgb lat%0d k=%0d: got %h want 000", lat_of(g), k, rgb_o[g]); end
          if (bl_o[g]  !== 1'b1)    begin n_bad++; $display("FAIL blank_flag lat%0d k=%0d: got %b want 1", lat_of(g), k, bl_o[g]); end
        end else begin
          if (rgb_o[g] !== 12'hFFF) begin n_bad++; $display("FAIL white_rgb lat%0d k=%0d: got %h want FFF", lat_of(g), k, rgb_o[g]); end
          if (bl_o[g]  !== 1'b0)    begin n_bad++; $display("FAIL white_blank lat%0d k=%0d: got %b want 0", lat_of(g), k, bl_o[g]); end
        end
      end
    end
  endtask

  // Async reset in the middle of a visible line, then restart from (0,0)
  task automatic test_reset_midframe();
    exp_t e;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 12'($urandom);
    test_mode = 1'b0;
    do_reset();
    for (int k = 1; k <= 5 * HT + 300; k++) begin @(posedge clk); #1; end
    #1 reset_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int g = 0; g < 3; g++) begin
        n_cmp += 5;
        if (rgb_o[g]  !== 12'h000) begin n_bad++; $display("FAIL mid_reset_rgb lat%0d c=%0d: got %h want 000", lat_of(g), c, rgb_o[g]); end
        if (bl_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL mid_reset_blank lat%0d c=%0d: got %b want 1", lat_of(g), c, bl_o[g]); end
        if (addr_o[g] !== 17'd0)   begin n_bad++; $display("FAIL mid_reset_addr lat%0d c=%0d: got %0d want 0", lat_of(g), c, addr_o[g]); end
        if (hs_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL mid_reset_hsync_n lat%0d c=%0d: got %b want 1", lat_of(g), c, hs_o[g]); end
        if (vs_o[g]   !== 1'b1)    begin n_bad++; $display("FAIL mid_reset_vsync_n lat%0d c=%0d: got %b want 1", lat_of(g), c, vs_o[g]); end
      end
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= 2 * HT; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        e = model(k, lat_of(g));
        n_cmp += 4;
        if (addr_o[g] !== e.addr)  begin n_bad++; $display("FAIL restart_addr lat%0d k=%0d: got %0d want %0d", lat_of(g), k, addr_o[g], e.addr); end
        if (rgb_o[g]  !== e.rgb)   begin n_bad++; $display("FAIL restart_rgb lat%0d k=%0d: got %h want %h", lat_of(g), k, rgb_o[g], e.rgb); end
        if (bl_o[g]   !== e.blank) begin n_bad++; $display("FAIL restart_blank lat%0d k=%0d: got %b want %b", lat_of(g), k, bl_o[g], e.blank); end
        if (hs_o[g]   !== e.hs_n)  begin n_bad++; $display("FAIL restart_hsync_n lat%0d k=%0d: got %b want %b", lat_of(g), k, hs_o[g], e.hs_n); end
        if (k == lat_of(g) + 2) begin
          n_cmp += 2;
          if (bl_o[g]  !== 1'b0)   begin n_bad++; $display("FAIL first_active_blank lat%0d: got %b want 0", lat_of(g), bl_o[g]); end
          if (rgb_o[g] !== mem[0]) begin n_bad++; $display("FAIL first_active_rgb lat%0d: got %h want %h", lat_of(g), rgb_o[g], mem[0]); end
        end
      end
    end
  endtask

  // Test-pattern mode: colour bars when the option is built in, buffer data otherwise
  task automatic test_pattern();
    exp_t e;
    logic [11:0] want85, want639;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 12'($urandom);
    test_mode = 1'b1;
`ifdef TEST_PATTERN_EN
    want85 = 12'h00F; want639 = 12'hFFF;
`else
    want85 = mem[42]; want639 = mem[319];
`endif
    do_reset();
    for (int k = 1; k <= HT + 8; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        e = model(k, lat_of(g));
        n_cmp += 2;
        if (rgb_o[g] !== e.rgb)   begin n_bad++; $display("FAIL pattern_rgb lat%0d k=%0d: got %h want %h", lat_of(g), k, rgb_o[g], e.rgb); end
        if (bl_o[g]  !== e.blank) begin n_bad++; $display("FAIL pattern_blank lat%0d k=%0d: got %b want %b", lat_of(g), k, bl_o[g], e.blank); end
        if (k == 85 + lat_of(g) + 2) begin
          n_cmp++;
          if (rgb_o[g] !== want85) begin n_bad++; $display("FAIL pattern_col85 lat%0d: got %h want %h", lat_of(g), rgb_o[g], want85); end
        end
        if (k == 639 + lat_of(g) + 2) begin
          n_cmp++;
          if (rgb_o[g] !== want639) begin n_bad++; $display("FAIL pattern_col639 lat%0d: got %h want %h", lat_of(g), rgb_o[g], want639); end
        end
      end
    end
    test_mode = 1'b0;
  endtask

  // Random buffer contents and random mode over a whole frame
  task automatic test_random();
    exp_t e;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 12'($urandom);
    test_mode = 1'($urandom_range(0, 1));
    do_reset();
    for (int k = 1; k <= HT * VT + 6; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        e = model(k, lat_of(g));
        n_cmp += 3;
        if (addr_o[g] !== e.addr)  begin n_bad++; $display("FAIL random_addr lat%0d k=%0d: got %0d want %0d", lat_of(g), k, addr_o[g], e.addr); end
        if (rgb_o[g]  !== e.rgb)   begin n_bad++; $display("FAIL random_rgb lat%0d k=%0d: got %h want %h", lat_of(g), k, rgb_o[g], e.rgb); end
        if (bl_o[g]   !== e.blank) begin n_bad++; $display("FAIL random_blank lat%0d k=%0d: got %b want %b", lat_of(g), k, bl_o[g], e.blank); end
      end
    end
    test_mode = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 12'h000;
    test_reset();
    test_frames();
    test_blanking();
    test_reset_midframe();
    test_pattern();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
